// File: rtl/fetch_queue_pipe_pkg.sv
// Shared types and default constants for the IF->ID instruction fetch queue.
package fetch_pkg;

  localparam int          DEFAULT_DEPTH     = 4;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_pipe_if.sv
// IF/ID handshake bundle: master is the pipeline side, slave is the fetch queue.
interface fetch_queue_pipe_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  logic [31:0]                InstrF;
  logic [31:0]                PCPlus4F;
  logic                       ValidF;
  logic                       StallF;
  logic                       StallD;
  logic                       FlushD;
  logic [31:0]                InstrD;
  logic [31:0]                PCPlus4D;
  logic                       ValidD;
  logic [$clog2(DEPTH+1)-1:0] CountQ;

  modport master (
    output InstrF, PCPlus4F, ValidF, StallD, FlushD,
    input  StallF, InstrD, PCPlus4D, ValidD, CountQ
  );

  modport slave (
    input  InstrF, PCPlus4F, ValidF, StallD, FlushD,
    output StallF, InstrD, PCPlus4D, ValidD, CountQ
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry storage: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  // Storage carries no reset; occupancy is tracked by the owning queue.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue_pipe.sv
// Instruction fetch queue between IF and ID with flush on taken branch.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards IF straight to ID when the queue is empty.
module fetch_queue_pipe
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input logic               clk,
  input logic               rst,
  fetch_queue_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;
  logic          full;
  logic          not_empty;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = ~not_empty & bus.ValidF & ~bus.FlushD;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed by ID in the same cycle never touches storage.
  assign push        = bus.ValidF & ~full & ~bus.FlushD;
  assign pop         = bus.ValidD & ~bus.StallD & ~bus.FlushD;
  assign bypass_take = bypass & ~bus.StallD;
  assign wr_en       = push & ~bypass_take;
  assign rd_en       = pop & ~bypass_take;

  assign wr_entry.instr   = bus.InstrF;
  assign wr_entry.pcplus4 = bus.PCPlus4F;

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.StallF = full;
  assign bus.CountQ = count;

  always_comb begin
    bus.ValidD   = not_empty | bypass;
    bus.InstrD   = NOP_INSTR;
    bus.PCPlus4D = 32'h0;
    if (not_empty) begin
      bus.InstrD   = rd_entry.instr;
      bus.PCPlus4D = rd_entry.pcplus4;
    end else if (bypass) begin
      bus.InstrD   = bus.InstrF;
      bus.PCPlus4D = bus.PCPlus4F;
    end
  end

  // Flush outranks push and pop and realigns both pointers to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.FlushD) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue_pipe.md
Name: fetch_queue_pipe

Overview:
- Instruction fetch queue between the IF stage (PC register, PC+4 adder, instruction memory read) and the ID stage of the 5-stage MIPS pipeline.
- Buffers up to DEPTH fetched {instruction, PC+4} pairs so that ID stalls do not immediately back-pressure PC update.
- Drives StallF back to the PC register when full.
- Discards all buffered entries when a branch resolves taken in MEM (FlushD, driven from PCSrcM).

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0000, instruction presented on InstrD when the queue is empty (sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- InstrF  in  32  instruction read at pcF.
- PCPlus4F  in  32  pcF+4 from the IF adder.
- ValidF  in  1  InstrF/PCPlus4F valid this cycle.
- StallF  out  1  queue full; the PC register must hold.
- StallD  in  1  ID stalled (hazard unit); head is not consumed.
- FlushD  in  1  taken branch resolved; discard all entries.
- InstrD  out  32  head instruction to ID.
- PCPlus4D  out  32  head PC+4 to ID.
- ValidD  out  1  head entry valid.
- CountQ  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset is asynchronous and active-high on rst. On reset: wr_ptr=0, rd_ptr=0, CountQ=0, ValidD=0, StallF=0, InstrD=NOP_INSTR, PCPlus4D=0. Storage contents are don't-care.
- push = ValidF & ~StallF & ~FlushD.
- pop = ValidD & ~StallD & ~FlushD.
- StallF = (CountQ == DEPTH). It is a pure function of registered state, with no combinational path from StallD.
- ValidD = (CountQ != 0).
- InstrD and PCPlus4D show storage[rd_ptr] when ValidD=1, else NOP_INSTR and 0.
- Latency: an entry pushed at edge N appears on the outputs after edge N (1 cycle).
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- CountQ update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged; write and read both occur.
- Full: StallF=1 blocks push. A pop in that cycle frees one slot, and StallF drops the following cycle.
- Empty: pop is impossible, and NOP_INSTR is presented on InstrD.
- FlushD=1 has priority over push and pop. At the next edge: CountQ=0, wr_ptr=rd_ptr=0, and that cycle's InstrF is dropped.
- FlushD combined with StallD still flushes.
- rst asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when CountQ==0, ValidF=1 and FlushD=0:
  - InstrF/PCPlus4F are forwarded combinationally to InstrD/PCPlus4D with ValidD=1 (0-cycle latency).
  - If StallD=0 the entry is consumed and not written.
  - If StallD=1 it is written normally.
- Not defined: fixed 1-cycle latency, with no combinational path from the IF inputs to the ID outputs.

Decomposition:
- Shared package fetch_pkg holds:
  - the NOP_INSTR constant;
  - the typedef fq_entry_t {instr[31:0], pcplus4[31:0]};
  - the default DEPTH constant.
- One sub-module, fetch_queue_mem: DEPTH x 64 register array, one synchronous write port and one asynchronous read port.
- Pointers, count, flush and handshake logic stay in fetch_queue_pipe.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release → ValidD=0, InstrD=0, StallF=0, CountQ=0.
- Streaming: ValidF=1 with InstrF=0x20080001, 0x20090002, 0x200A0003 on consecutive cycles, StallD=0 → same sequence on InstrD one cycle later each; CountQ stays ≤1.
- Fill: StallD=1 and push 5 instructions → after 4 pushes CountQ=4 and StallF=1; the 5th is not accepted. Release StallD → 4 entries delivered in FIFO order, StallF=0 one cycle after the first pop.
- Flush: queue holds 3 entries; assert FlushD with ValidF=1 and InstrF=0xDEADBEEF → next cycle CountQ=0, ValidD=0, and 0xDEADBEEF never appears on InstrD.
- Wrap-around: push/pop 10 entries with random StallD (seeded) → output order equals input order; no pointer corruption across wraps.
- Bypass (macro defined): empty queue, ValidF=1, InstrF=0x8C080004, StallD=0 → InstrD=0x8C080004 in the same cycle and CountQ stays 0.
